letc_core_stage_m: RTL
======================

LETC_CORE_STAGE_M -- requirements
Module: letc_core_stage_m

Interface
REQ-001 The block SHALL have no parameters; types come from letc_core_pkg and riscv_pkg.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low, with ports named i_clk and i_rst_n.
REQ-003 The block SHALL expose these ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_e_to_m  in  e_to_m_s  execute-stage result
- i_stall  in  1  downstream/adhesive hold
- i_flush  in  1  discard in-flight and incoming instruction
- o_m_to_w  out  m_to_w_s  registered writeback payload
- o_busy  out  1  upstream SHALL hold i_e_to_m stable while high
- o_mem_fault  out  1  one-cycle pulse: misaligned access or illegal size
- o_dmem_req_valid  out  1  bus request
- i_dmem_req_ready  in  1  bus accepts request
- o_dmem_addr  out  32  word-aligned address
- o_dmem_wen  out  1  1=store
- o_dmem_wstrb  out  4  byte lanes
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_rsp_valid  in  1  load data / store ack
- i_dmem_rdata  in  32  raw word read

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, DRAIN; o_busy = (state != IDLE).
REQ-005 Accept condition SHALL be: IDLE and i_e_to_m.valid and !i_stall and !i_flush.
REQ-006 On accept with memory_op == MEM_OP_NOP, o_m_to_w SHALL be loaded next cycle: valid=1, memory_rdata=0, all other fields copied; latency 1 cycle.
REQ-007 On accept with a LOAD/STORE memop that is aligned, the block SHALL capture the transaction into internal registers, drive o_m_to_w.valid=0, and go to REQ.
REQ-008 Misalignment SHALL be: HALFWORD with addr[0]!=0, WORD with addr[1:0]!=0, or size==2'b11. On accept of such an op, the block SHALL pulse o_mem_fault for 1 cycle, drive o_m_to_w.valid=0, issue no request, and stay in IDLE.
REQ-009 In REQ, o_dmem_req_valid SHALL be 1 and all request outputs SHALL be stable until i_dmem_req_ready=1, after which the state goes to WAIT.
REQ-010 o_dmem_addr SHALL equal {alu_result[31:2],2'b00}.
REQ-011 o_dmem_wen SHALL be 1 for stores.
REQ-012 o_dmem_wstrb SHALL be:
- BYTE: 4'b0001<<addr[1:0]
- HALF: 4'b0011<<{addr[1],1'b0}
- WORD: 4'b1111
- Loads: same strobe.
REQ-013 o_dmem_wdata SHALL be rs2_rdata[7:0] replicated x4 (BYTE), rs2_rdata[15:0] replicated x2 (HALF), or rs2_rdata (WORD).
REQ-014 In WAIT, on i_dmem_rsp_valid, the block SHALL write o_m_to_w next cycle with valid=1 and the captured fields; the state goes to IDLE.
REQ-015 Load memory_rdata SHALL be (i_dmem_rdata >> 8*addr[1:0]), truncated to the access size, then sign-extended if memory_signed else zero-extended; store memory_rdata SHALL be 0.
REQ-016 Minimum memop latency SHALL be 3 cycles (accept, REQ with ready=1, WAIT with rsp=1); the output is valid the cycle after rsp.
REQ-017 When i_stall=1, o_m_to_w SHALL hold its value and IDLE SHALL NOT accept; REQ/WAIT SHALL progress regardless, and the WAIT result SHALL be held internally until i_stall falls.
REQ-018 i_flush in IDLE SHALL drop the input and set o_m_to_w.valid=0 next cycle.
REQ-019 i_flush in REQ with i_dmem_req_ready=0 SHALL deassert the request next cycle and go to IDLE.
REQ-020 i_flush in REQ with ready=1, or in WAIT, SHALL go to DRAIN; DRAIN waits for i_dmem_rsp_valid, discards the data, then goes to IDLE; output valid stays 0; an accepted store is not cancelled.
REQ-021 i_dmem_rsp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-022 While i_rst_n=0, the state SHALL be IDLE, o_m_to_w SHALL be all-zero (valid=0), and all o_dmem_* outputs, o_busy, and o_mem_fault SHALL be 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction immediately with no output; after release, the block SHALL accept on the first valid cycle.

Verification
REQ-024 Signed LB, alu_result=0x1003, rdata=0x80000000, ready/rsp immediate -> wstrb=4'b1000, wen=0, memory_rdata=0xFFFFFF80, valid=1 three cycles after accept.
REQ-025 SH, alu_result=0x2002, rs2=0x1234ABCD, ready stalled 2 cycles -> req_valid held 3 cycles, addr=0x2000, wstrb=4'b1100, wdata=0xABCDABCD, o_busy high throughout.
REQ-026 NOP memop, alu_result=0x55, rd_idx=5 -> next cycle valid=1, alu_result=0x55, no req_valid, o_busy=0.
REQ-027 LW at 0x3001 -> o_mem_fault 1 cycle, no request, valid=0; following aligned LW completes normally.
REQ-028 Flush in WAIT, rsp arrives 4 cycles later -> DRAIN, valid never 1, o_busy falls the cycle after rsp; separately, a flush in REQ with ready=0 -> request withdrawn next cycle.
REQ-029 Reset asserted during WAIT, then stray rsp after release -> all outputs 0, rsp ignored, state IDLE.

Source files
------------

// File: rtl/letc_core_stage_m.sv
// rtl/letc_core_stage_m.sv - memory stage: data-bus load/store sequencing and writeback register

package riscv_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;
endpackage

package letc_core_pkg;
    import riscv_pkg::*;

    typedef enum logic [1:0] {
        MEM_OP_NOP   = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } memory_op_e;

    // Access size is a raw 2-bit field so the illegal encoding 2'b11 stays representable.
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef struct packed {
        logic       valid;
        reg_idx_t   rd_idx;
        logic       rd_we;
        word_t      alu_result;
        word_t      rs2_rdata;
        memory_op_e memory_op;
        logic [1:0] memory_size;
        logic       memory_signed;
    } e_to_m_s;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd_idx;
        logic     rd_we;
        word_t    alu_result;
        word_t    memory_rdata;
    } m_to_w_s;
endpackage

module letc_core_stage_m
    import riscv_pkg::*;
    import letc_core_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  e_to_m_s    i_e_to_m,
    input  logic       i_stall,
    input  logic       i_flush,
    output m_to_w_s    o_m_to_w,
    output logic       o_busy,
    output logic       o_mem_fault,
    output logic       o_dmem_req_valid,
    input  logic       i_dmem_req_ready,
    output logic [31:0] o_dmem_addr,
    output logic       o_dmem_wen,
    output logic [3:0] o_dmem_wstrb,
    output logic [31:0] o_dmem_wdata,
    input  logic       i_dmem_rsp_valid,
    input  logic [31:0] i_dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_e;

    state_e  state_q, state_d;
    e_to_m_s txn_q;
    logic    rsp_held_q;
    word_t   rsp_data_q;
    m_to_w_s out_q;
    logic    fault_q;

    logic    accept;
    logic    is_memop;
    logic    misaligned;
    logic    deliver;
    logic    hold_rsp;
    m_to_w_s payload;

    function automatic word_t load_extract(input word_t raw, input logic [1:0] off,
                                           input logic [1:0] size, input logic sgn);
        word_t sh;
        sh = raw >> {off, 3'b000};
        case (size)
            MEM_SIZE_BYTE: return {{24{sgn & sh[7]}}, sh[7:0]};
            MEM_SIZE_HALF: return {{16{sgn & sh[15]}}, sh[15:0]};
            default:       return sh;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            MEM_SIZE_BYTE: return 4'b0001 << off;
            MEM_SIZE_HALF: return 4'b0011 << {off[1], 1'b0};
            default:       return 4'b1111;
        endcase
    endfunction

    function automatic word_t lane_data(input logic [1:0] size, input word_t rs2);
        case (size)
            MEM_SIZE_BYTE: return {4{rs2[7:0]}};
            MEM_SIZE_HALF: return {2{rs2[15:0]}};
            default:       return rs2;
        endcase
    endfunction

    assign accept   = (state_q == IDLE) && i_e_to_m.valid && !i_stall && !i_flush;
    assign is_memop = (i_e_to_m.memory_op != MEM_OP_NOP);
    assign misaligned = ((i_e_to_m.memory_size == MEM_SIZE_HALF) && i_e_to_m.alu_result[0])
                     || ((i_e_to_m.memory_size == MEM_SIZE_WORD) && (i_e_to_m.alu_result[1:0] != 2'b00))
                     || (i_e_to_m.memory_size == 2'b11);

    // Next state, writeback payload, and whether a stalled response must be parked.
    always_comb begin
        state_d  = state_q;
        deliver  = 1'b0;
        hold_rsp = 1'b0;
        payload  = '0;
        if (state_q == IDLE) begin
            payload.valid      = 1'b1;
            payload.rd_idx     = i_e_to_m.rd_idx;
            payload.rd_we      = i_e_to_m.rd_we;
            payload.alu_result = i_e_to_m.alu_result;
        end else begin
            payload.valid      = txn_q.valid;
            payload.rd_idx     = txn_q.rd_idx;
            payload.rd_we      = txn_q.rd_we;
            payload.alu_result = txn_q.alu_result;
            if (txn_q.memory_op == MEM_OP_LOAD) begin
                payload.memory_rdata = load_extract(rsp_held_q ? rsp_data_q : i_dmem_rdata,
                                                    txn_q.alu_result[1:0], txn_q.memory_size,
                                                    txn_q.memory_signed);
            end
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_memop) begin
                        deliver = 1'b1;
                    end else if (!misaligned) begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (i_flush) begin
                    state_d = i_dmem_req_ready ? DRAIN : IDLE;
                end else if (i_dmem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_flush) begin
                    // A response already in hand (or arriving now) means nothing is left to drain.
                    state_d = (rsp_held_q || i_dmem_rsp_valid) ? IDLE : DRAIN;
                end else if (rsp_held_q || i_dmem_rsp_valid) begin
                    if (!i_stall) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else if (!rsp_held_q) begin
                        hold_rsp = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (i_dmem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register and captured transaction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            txn_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= accept && is_memop && misaligned;
            if (accept) begin
                txn_q <= i_e_to_m;
            end
        end
    end

    // Parks a load response that arrives while writeback is stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_held_q <= 1'b0;
            rsp_data_q <= '0;
        end else if (hold_rsp) begin
            rsp_held_q <= 1'b1;
            rsp_data_q <= i_dmem_rdata;
        end else if (state_d != WAIT) begin
            rsp_held_q <= 1'b0;
        end
    end

    // Writeback register: holds under stall, flush clears valid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q <= '0;
        end else if (deliver) begin
            out_q <= payload;
        end else if (i_flush || !i_stall) begin
            out_q.valid <= 1'b0;
        end
    end

    assign o_m_to_w         = out_q;
    assign o_busy           = (state_q != IDLE);
    assign o_mem_fault      = fault_q;
    assign o_dmem_req_valid = (state_q == REQ);
    assign o_dmem_addr      = o_dmem_req_valid ? {txn_q.alu_result[31:2], 2'b00} : 32'h0;
    assign o_dmem_wen       = o_dmem_req_valid && (txn_q.memory_op == MEM_OP_STORE);
    assign o_dmem_wstrb     = o_dmem_req_valid ? lane_strobe(txn_q.memory_size, txn_q.alu_result[1:0]) : 4'b0000;
    assign o_dmem_wdata     = o_dmem_req_valid ? lane_data(txn_q.memory_size, txn_q.rs2_rdata) : 32'h0;

endmodule
